// File: rtl/lizwiz_pkg.sv
// -----------------------------------------------------------------------------
// lizwiz_pkg
// Shared definitions for the ROM download / core-read arbiter:
//   - default shared-ROM address width and post-download reset stretch length
//   - width of the HPS download byte address
//   - arbiter state encoding
// -----------------------------------------------------------------------------
package lizwiz_pkg;

  localparam int unsigned AW_DEF       = 16;  // shared ROM address width
  localparam int unsigned RST_HOLD_DEF = 16;  // clk_sys cycles of core_reset after download
  localparam int unsigned IOCTL_AW     = 25;  // HPS download byte address width

  // RUN  : core owns the RAM, core_reset low
  // LOAD : HPS download owns the RAM, core held in reset
  // HOLD : download finished, core_reset stretched before releasing the core
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } dl_state_e;

endpackage : lizwiz_pkg

// File: rtl/rom_dl_arbiter_rst_stretch.sv
// -----------------------------------------------------------------------------
// rst_stretch
// Down-counter that stretches the core reset after a download.
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset, reloads the counter
//   i_load  : reload the counter with RST_HOLD
//   i_count : decrement by one (saturates at zero)
//   o_done  : high when the counter is on its final count, i.e. a counting
//             edge now takes it to zero
// -----------------------------------------------------------------------------
module rst_stretch
  import lizwiz_pkg::*;
#(
  parameter int unsigned RST_HOLD = RST_HOLD_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_done
);

  localparam int unsigned          CW       = $clog2(RST_HOLD + 2);
  localparam logic [CW-1:0]        LOAD_VAL = CW'(RST_HOLD);
  localparam logic [CW-1:0]        ONE      = CW'(1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of process order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= LOAD_VAL;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  // Flagging the last count (rather than zero) lets the FSM leave HOLD on the
  // same edge the counter reaches zero, giving exactly RST_HOLD HOLD cycles.
  assign o_done = (r_cnt <= ONE);

endmodule : rst_stretch

// File: rtl/rom_dl_arbiter.sv
// -----------------------------------------------------------------------------
// rom_dl_arbiter
// Shares one single-port RAM (1-cycle synchronous read) between an HPS ROM
// download and the game core's read port, and holds the core in reset while
// the download runs plus RST_HOLD cycles afterwards.
//
// Ports
//   clk_sys        : system clock, every flop on its rising edge
//   RESET          : asynchronous active-high reset
//   ioctl_download : high while an HPS download is in progress
//   ioctl_wr       : single-cycle download byte strobe
//   ioctl_addr     : download byte address (25 bits)
//   ioctl_dout     : download byte
//   cpu_ce         : core read strobe
//   cpu_addr       : core read address
//   cpu_dout       : last byte read by the core
//   cpu_valid      : one-cycle pulse when cpu_dout is fresh
//   mem_addr/din/we: RAM address, write data and write enable
//   mem_dout       : RAM read data (valid one cycle after the address)
//   core_reset     : reset to the game core (high in LOAD and HOLD)
//   dl_busy        : high in LOAD
//   dl_overflow    : sticky, a download byte above the RAM was dropped
// -----------------------------------------------------------------------------
module rom_dl_arbiter
  import lizwiz_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned RST_HOLD = RST_HOLD_DEF
) (
  input  logic                clk_sys,
  input  logic                RESET,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  input  logic                cpu_ce,
  input  logic [AW-1:0]       cpu_addr,
  output logic [7:0]          cpu_dout,
  output logic                cpu_valid,
  output logic [AW-1:0]       mem_addr,
  output logic [7:0]          mem_din,
  output logic                mem_we,
  input  logic [7:0]          mem_dout,
  output logic                core_reset,
  output logic                dl_busy,
  output logic                dl_overflow
);

  dl_state_e     r_state;
  dl_state_e     w_next;
  logic          w_hold_done;

  logic          r_core_reset;
  logic          r_dl_busy;
  logic          r_overflow;

  logic          w_in_range;
  logic          w_take;

  // Write pipeline: stage 1 captures the strobe, stage 2 drives the RAM.
  logic          r_wr_pend;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_mem_din;

  // Read pipeline: the RAM registers the address on the strobe edge, the
  // returned byte is captured one edge later.
  logic          r_rd_pend;
  logic [7:0]    r_cpu_dout;
  logic          r_cpu_valid;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_state <= HOLD;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: w_next gets its default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    if (ioctl_download) begin
      w_next = LOAD;
    end else begin
      unique case (r_state)
        LOAD:    w_next = HOLD;
        HOLD:    w_next = w_hold_done ? RUN : HOLD;
        RUN:     w_next = RUN;
        default: w_next = HOLD;
      endcase
    end
  end

  // Held in reload during LOAD so the count starts at RST_HOLD on the
  // LOAD->HOLD edge.
  rst_stretch #(
    .RST_HOLD (RST_HOLD)
  ) u_rst_stretch (
    .i_clk   (clk_sys),
    .i_rst   (RESET),
    .i_load  (r_state == LOAD),
    .i_count (r_state == HOLD),
    .o_done  (w_hold_done)
  );

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_core_reset <= 1'b1;
      r_dl_busy    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_core_reset <= (w_next != RUN);
      r_dl_busy    <= (w_next == LOAD);
      if ((w_next == LOAD) && (r_state != LOAD)) begin
        r_overflow <= 1'b0;
      end else if (w_take && !w_in_range) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Download write path
  // ---------------------------------------------------------------------------
  assign w_in_range = (ioctl_addr[IOCTL_AW-1:AW] == '0);
  assign w_take     = (r_state == LOAD) && ioctl_wr;

  // The pipeline drains independently of the state, so a write accepted on
  // the last LOAD edges still lands during HOLD. Only RESET aborts it.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_wr_pend  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      r_wr_pend <= w_take && w_in_range;
      r_mem_we  <= r_wr_pend;
      if (r_wr_pend) begin
        r_mem_addr <= r_wr_addr;
        r_mem_din  <= r_wr_data;
      end
    end
  end

  // NOTE: pure datapath registers qualified by r_wr_pend carry no reset; their
  // contents are never used before a strobe has loaded them.
  always_ff @(posedge clk_sys) begin
    if (w_take) begin
      r_wr_addr <= ioctl_addr[AW-1:0];
      r_wr_data <= ioctl_dout;
    end
  end

  // ---------------------------------------------------------------------------
  // Core read path
  // ---------------------------------------------------------------------------
  // A read is only launched or completed while RUN is kept across the edge,
  // so leaving RUN discards anything in flight.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_rd_pend   <= 1'b0;
      r_cpu_dout  <= '0;
      r_cpu_valid <= 1'b0;
    end else begin
      r_rd_pend   <= cpu_ce && (r_state == RUN) && (w_next == RUN);
      r_cpu_valid <= r_rd_pend && (w_next == RUN);
      if (r_rd_pend && (w_next == RUN)) begin
        r_cpu_dout <= mem_dout;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_addr    = (r_state == RUN) ? cpu_addr : r_mem_addr;
  assign mem_din     = r_mem_din;
  assign mem_we      = r_mem_we && (r_state != RUN);
  assign cpu_dout    = r_cpu_dout;
  assign cpu_valid   = r_cpu_valid;
  assign core_reset  = r_core_reset;
  assign dl_busy     = r_dl_busy;
  assign dl_overflow = r_overflow;

endmodule : rom_dl_arbiter

// File: doc/rom_dl_arbiter.md
ROM_DL_ARBITER -- requirements
Module: rom_dl_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, meaning shared ROM address width in bits.
REQ-002 SHALL have parameter RST_HOLD, default 16, meaning clk_sys cycles core_reset stays high after download ends.
REQ-003 SHALL have port clk_sys, input, 1, the single system clock; every flop is on its rising edge.
REQ-004 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ioctl_download, input, 1, level high while an HPS download is in progress.
REQ-006 SHALL have port ioctl_wr, input, 1, single-cycle byte-write strobe.
REQ-007 SHALL have port ioctl_addr, input, 25, download byte address.
REQ-008 SHALL have port ioctl_dout, input, 8, download byte.
REQ-009 SHALL have port cpu_ce, input, 1, core read strobe (ENA_6 rate).
REQ-010 SHALL have port cpu_addr, input, AW, core read address.
REQ-011 SHALL have port cpu_dout, output, 8, last read byte.
REQ-012 SHALL have port cpu_valid, output, 1, one-cycle pulse marking a fresh cpu_dout.
REQ-013 SHALL have ports mem_addr (output, AW), mem_din (output, 8), mem_we (output, 1) and mem_dout (input, 8): a single-port RAM with a one-cycle synchronous read.
REQ-014 SHALL have port core_reset, output, 1, reset to the game core.
REQ-015 SHALL have port dl_busy, output, 1, high in LOAD.
REQ-016 SHALL have port dl_overflow, output, 1, sticky flag for a dropped out-of-range write.

Function
REQ-017 SHALL implement FSM states RUN, LOAD and HOLD.
REQ-018 SHALL, in any state, enter LOAD at the next edge when ioctl_download=1.
REQ-019 SHALL clear dl_overflow on entry to LOAD from RUN or HOLD.
REQ-020 SHALL, in LOAD, take a write when ioctl_wr is sampled at edge k with ioctl_addr[24:AW]==0, and drive mem_we=1, mem_addr=ioctl_addr[AW-1:0] and mem_din=ioctl_dout for exactly the cycle after edge k+1.
REQ-021 SHALL accept back-to-back ioctl_wr on every cycle with none lost.
REQ-022 SHALL drop a LOAD write with ioctl_addr[24:AW]!=0, keep mem_we=0 for it, and set dl_overflow=1.
REQ-023 SHALL ignore ioctl_wr outside LOAD.
REQ-024 SHALL, in LOAD, go to HOLD with the hold counter loaded with RST_HOLD when ioctl_download=0; a write registered on the last LOAD edge still completes in the first HOLD cycle.
REQ-025 SHALL, in HOLD, decrement the counter each cycle and enter RUN when it reaches 0, so HOLD lasts exactly RST_HOLD cycles.
REQ-026 SHALL drive core_reset=1 in LOAD and HOLD and 0 in RUN, registered to the state.
REQ-027 SHALL, in RUN, drive mem_addr=cpu_addr combinationally and mem_we=0.
REQ-028 SHALL, in RUN, capture mem_dout into cpu_dout at edge k+1 for cpu_ce sampled at edge k, and pulse cpu_valid for that one cycle.
REQ-029 SHALL, outside RUN, ignore cpu_ce, hold cpu_valid=0 and leave cpu_dout unchanged.
REQ-030 SHALL discard a cpu read in flight when RUN is left, so no cpu_valid pulse occurs after leaving RUN.

Reset
REQ-031 SHALL, while RESET=1, force state=HOLD, counter=RST_HOLD, core_reset=1, dl_busy=0, dl_overflow=0, mem_we=0, mem_addr=0, mem_din=0, cpu_dout=0 and cpu_valid=0.
REQ-032 SHALL, when RESET is asserted mid-LOAD, abort the pending write with no partial mem_we pulse.
REQ-033 SHALL, after RESET release, enter RUN after RST_HOLD cycles, or enter LOAD if ioctl_download=1.

Structure
REQ-034 SHALL place the state enum (RUN, LOAD, HOLD) and the defaults for AW and RST_HOLD in shared package lizwiz_pkg.
REQ-035 SHALL implement the hold counter as sub-module rst_stretch, with load, count and a done output.
REQ-036 SHALL keep all other logic flat within rom_dl_arbiter.

Verification
REQ-037 SHALL verify release to RUN: deassert RESET with ioctl_download=0 -> core_reset falls exactly 16 cycles later.
REQ-038 SHALL verify back-to-back writes: download with ioctl_wr on 4 consecutive cycles, addresses 0x0000-0x0003, data A5/5A/FF/00 -> 4 consecutive mem_we cycles, each 1 cycle after its strobe, with matching address and data.
REQ-039 SHALL verify out-of-range drop: a write to ioctl_addr 0x10000 -> no mem_we and dl_overflow=1; starting a new download clears dl_overflow to 0.
REQ-040 SHALL verify read latency in RUN: RAM[0x1234]=0x3C, cpu_ce with cpu_addr=0x1234 -> cpu_dout=0x3C and a 1-cycle cpu_valid at the next edge.
REQ-041 SHALL verify re-entry from HOLD: raise ioctl_download during HOLD cycle 8 -> back to LOAD, core_reset stays 1, and a full 16-cycle HOLD follows the second download.
REQ-042 SHALL verify reset mid-write: assert RESET in the cycle after an ioctl_wr -> no mem_we pulse, and all outputs at their REQ-031 values.
